// File: rtl/text_console_writer.sv
// rtl/text_console_writer.sv - character console front end that writes glyph/attribute pairs into text RAM
module text_console_writer #(
    parameter int COLS           = 80,
    parameter int ROWS           = 60,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic        clk_25,
    input  logic        resetN,
    input  logic [7:0]  char_in,
    input  logic [7:0]  attr_in,
    input  logic        char_valid,
    output logic        char_ready,
    input  logic        clear_req,
    output logic [13:0] text_add,
    output logic [7:0]  text_data,
    output logic        wr_en,
    output logic        busy,
    output logic [6:0]  cursor_col,
    output logic [5:0]  cursor_row
);

    typedef enum logic [1:0] {IDLE, WR_CHAR, WR_META, CLEAR} state_t;

    localparam logic [6:0] LAST_COL   = 7'(COLS - 1);
    localparam logic [5:0] LAST_ROW   = 6'(ROWS - 1);
    localparam logic       START_INIT = (CLEAR_ON_RESET != 0);

    state_t      state_q, state_d;
    logic [6:0]  col_q, col_d;
    logic [5:0]  row_q, row_d;
    logic [7:0]  char_q, char_d;
    logic [7:0]  attr_q, attr_d;
    logic        phase_q, phase_d;
    logic        start_q, start_d;

    logic [6:0]  adv_col;
    logic [5:0]  adv_row;
    logic [5:0]  lf_row;
    logic        printable;
    logic        wr_sel;

    // Cursor step after a cell write: wraps to (0,0) at the end of the screen.
    assign adv_col   = (col_q == LAST_COL) ? 7'd0 : col_q + 7'd1;
    assign lf_row    = (row_q == LAST_ROW) ? 6'd0 : row_q + 6'd1;
    assign adv_row   = (col_q == LAST_COL) ? lf_row : row_q;
    assign printable = (char_in >= 8'h20) && (char_in != 8'h7F);

    always_ff @(posedge clk_25 or negedge resetN) begin
        if (!resetN) begin
            state_q <= IDLE;
            col_q   <= '0;
            row_q   <= '0;
            char_q  <= '0;
            attr_q  <= '0;
            phase_q <= 1'b0;
            start_q <= START_INIT;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            char_q  <= char_d;
            attr_q  <= attr_d;
            phase_q <= phase_d;
            start_q <= start_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        col_d      = col_q;
        row_d      = row_q;
        char_d     = char_q;
        attr_d     = attr_q;
        phase_d    = phase_q;
        start_d    = start_q;
        wr_en      = 1'b0;
        wr_sel     = 1'b0;
        text_data  = 8'h00;
        char_ready = 1'b0;

        case (state_q)
            IDLE: begin
                // A pending power-on clear behaves like a clear request.
                char_ready = resetN & ~clear_req & ~start_q;
                if (start_q || clear_req) begin
                    state_d = CLEAR;
                    attr_d  = start_q ? 8'h07 : attr_in;
                    start_d = 1'b0;
                    col_d   = '0;
                    row_d   = '0;
                    phase_d = 1'b0;
                end else if (char_valid) begin
                    if (printable) begin
                        char_d  = char_in;
                        attr_d  = attr_in;
                        state_d = WR_CHAR;
                    end else begin
                        case (char_in)
                            8'h0D: col_d = '0;
                            8'h0A: begin
                                col_d = '0;
                                row_d = lf_row;
                            end
                            8'h08: if (col_q != 7'd0) col_d = col_q - 7'd1;
                            default: ;
                        endcase
                    end
                end
            end
            WR_CHAR: begin
                wr_en     = 1'b1;
                text_data = char_q;
                state_d   = WR_META;
            end
            WR_META: begin
                wr_en     = 1'b1;
                wr_sel    = 1'b1;
                text_data = attr_q;
                col_d     = adv_col;
                row_d     = adv_row;
                state_d   = IDLE;
            end
            CLEAR: begin
                // The cursor doubles as the sweep pointer, so it lands on (0,0) when done.
                wr_en     = 1'b1;
                wr_sel    = phase_q;
                text_data = phase_q ? attr_q : 8'h20;
                phase_d   = ~phase_q;
                if (phase_q) begin
                    col_d = adv_col;
                    row_d = adv_row;
                    if ((col_q == LAST_COL) && (row_q == LAST_ROW)) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign text_add   = wr_en ? {row_q, col_q, wr_sel} : 14'd0;
    assign busy       = (state_q != IDLE);
    assign cursor_col = col_q;
    assign cursor_row = row_q;

endmodule
